// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor / BTB: counter encodings,
// default table geometry and entry field widths.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  localparam int DEFAULT_INDEX_BITS = 3;
  localparam int PC_W               = 16;
  localparam int TARGET_W           = 16;

  // Tag covers the PC bits above the index; PC[0] is never used.
  function automatic int tag_w(input int index_bits);
    return 15 - index_bits;
  endfunction

  localparam int TAG_W = tag_w(DEFAULT_INDEX_BITS);

endpackage

// File: rtl/sat_counter_2bit.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_counter_2bit
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != STRONG_T) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != STRONG_NT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor + BTB: combinational lookup on the fetch PC,
// training from the decode stage, and mispredict / corrected-PC generation.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC_curr,
  output logic        predicted_taken,
  output logic [15:0] predicted_target,
  input  logic        update_en,
  input  logic [15:0] ID_PC,
  input  logic        ID_is_branch,
  input  logic        ID_actual_taken,
  input  logic [15:0] ID_actual_target,
  input  logic        ID_predicted_taken,
  input  logic [15:0] ID_predicted_target,
  output logic        mispredicted,
  output logic [15:0] correct_PC
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TW      = tag_w(INDEX_BITS);

  logic              valid_q  [ENTRIES];
  logic [TW-1:0]     tag_q    [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [TARGET_W-1:0] target_q [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx, upd_idx;
  logic [TW-1:0]         lk_tag, upd_tag;
  logic                  lk_hit, upd_hit, upd_fire;
  logic [1:0]            ctr_next;

  assign lk_idx  = PC_curr[INDEX_BITS:1];
  assign lk_tag  = PC_curr[15:INDEX_BITS+1];
  assign upd_idx = ID_PC[INDEX_BITS:1];
  assign upd_tag = ID_PC[15:INDEX_BITS+1];

  // PC[0] is architecturally ignored.
  logic unused_pc_lsb;
  assign unused_pc_lsb = PC_curr[0] ^ ID_PC[0];

  // Lookup reads the current table only; a same-cycle update is not bypassed.
  assign lk_hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign predicted_taken  = lk_hit && ctr_q[lk_idx][1];
  assign predicted_target = lk_hit ? target_q[lk_idx] : 16'h0000;

  assign upd_fire = update_en && ID_is_branch;
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  sat_counter_2bit u_ctr (
    .ctr      (ctr_q[upd_idx]),
    .taken    (ID_actual_taken),
    .ctr_next (ctr_next)
  );

  // NOTE: the tables are small flop arrays, so every entry is reset explicitly;
  // this also makes a reset cancel any update sampled in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= WEAK_NT;
        target_q[i] <= '0;
      end
    end else if (upd_fire) begin
      // NOTE: sequential state uses non-blocking assignments only.
      valid_q[upd_idx] <= 1'b1;
      tag_q[upd_idx]   <= upd_tag;
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next;
        if (ID_actual_taken) target_q[upd_idx] <= ID_actual_target;
      end else begin
        ctr_q[upd_idx]    <= ID_actual_taken ? WEAK_T : WEAK_NT;
        target_q[upd_idx] <= ID_actual_target;
      end
    end
  end

  // Not gated by update_en: a stalled branch keeps requesting its flush.
  assign mispredicted = ID_is_branch &&
                        ((ID_predicted_taken != ID_actual_taken) ||
                         (ID_actual_taken && (ID_predicted_target != ID_actual_target)));

  assign correct_PC = ID_actual_taken ? ID_actual_target : (ID_PC + 16'd2);

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor with an expected-result queue,
// plus hand sequences for asynchronous reset behaviour.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] PC_curr;
  logic        predicted_taken;
  logic [15:0] predicted_target;
  logic        update_en;
  logic [15:0] ID_PC;
  logic        ID_is_branch;
  logic        ID_actual_taken;
  logic [15:0] ID_actual_target;
  logic        ID_predicted_taken;
  logic [15:0] ID_predicted_target;
  logic        mispredicted;
  logic [15:0] correct_PC;

  branch_predictor dut (
    .clk                 (clk),
    .rst                 (rst),
    .PC_curr             (PC_curr),
    .predicted_taken     (predicted_taken),
    .predicted_target    (predicted_target),
    .update_en           (update_en),
    .ID_PC               (ID_PC),
    .ID_is_branch        (ID_is_branch),
    .ID_actual_taken     (ID_actual_taken),
    .ID_actual_target    (ID_actual_target),
    .ID_predicted_taken  (ID_predicted_taken),
    .ID_predicted_target (ID_predicted_target),
    .mispredicted        (mispredicted),
    .correct_PC          (correct_PC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        upd;
    logic [15:0] id_pc;
    logic        br;
    logic        at;
    logic [15:0] atgt;
    logic        pt;
    logic [15:0] ptgt;
    logic [15:0] lpc;
    logic        e_t;
    logic [15:0] e_tgt;
    logic        e_mp;
    logic [15:0] e_cpc;
  } vec_t;

  typedef struct {
    logic        e_t;
    logic [15:0] e_tgt;
    logic        e_mp;
    logic [15:0] e_cpc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic upd, input logic [15:0] id_pc, input logic br,
                     input logic at, input logic [15:0] atgt, input logic pt,
                     input logic [15:0] ptgt, input logic [15:0] lpc, input logic e_t,
                     input logic [15:0] e_tgt, input logic e_mp, input logic [15:0] e_cpc);
    vec_t v;
    v = '{upd, id_pc, br, at, atgt, pt, ptgt, lpc, e_t, e_tgt, e_mp, e_cpc};
    vecs.push_back(v);
  endtask

  task automatic drive_idle(input logic [15:0] lpc);
    update_en = 0; ID_PC = 16'h0000; ID_is_branch = 0; ID_actual_taken = 0;
    ID_actual_target = 16'h0000; ID_predicted_taken = 0; ID_predicted_target = 16'h0000;
    PC_curr = lpc;
  endtask

  task automatic check_lookup(input string name, input logic e_t, input logic [15:0] e_tgt);
    check({name, ".taken"}, {15'd0, predicted_taken}, {15'd0, e_t});
    check({name, ".target"}, predicted_target, e_tgt);
  endtask

  initial begin
    exp_t e;
    // upd id_pc   br at atgt     pt ptgt     lookup   e_t e_tgt    mp cpc
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 0, 16'h0000, 0, 16'h0002);
    add(1, 16'h0010, 1, 1, 16'h0040, 0, 16'h0000, 16'h0010, 0, 16'h0000, 1, 16'h0040);
    add(1, 16'h0010, 1, 0, 16'h0040, 1, 16'h0040, 16'h0010, 1, 16'h0040, 1, 16'h0012);
    add(1, 16'h0010, 1, 0, 16'h0040, 0, 16'h0040, 16'h0010, 0, 16'h0040, 0, 16'h0012);
    add(1, 16'h0010, 1, 1, 16'h0040, 0, 16'h0040, 16'h0010, 0, 16'h0040, 1, 16'h0040);
    add(1, 16'h0010, 1, 1, 16'h0040, 0, 16'h0040, 16'h0010, 0, 16'h0040, 1, 16'h0040);
    add(1, 16'h0010, 1, 1, 16'h0050, 1, 16'h0040, 16'h0010, 1, 16'h0040, 1, 16'h0050);
    add(1, 16'h0010, 1, 1, 16'h0050, 1, 16'h0050, 16'h0010, 1, 16'h0050, 0, 16'h0050);
    add(1, 16'h0010, 1, 0, 16'h0050, 1, 16'h0050, 16'h0010, 1, 16'h0050, 1, 16'h0012);
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 16'h0050, 0, 16'h0002);
    add(0, 16'h0010, 1, 0, 16'h0050, 1, 16'h0050, 16'h0010, 1, 16'h0050, 1, 16'h0012);
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 16'h0050, 0, 16'h0002);
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0011, 1, 16'h0050, 0, 16'h0002);
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0012, 0, 16'h0000, 0, 16'h0002);
    add(1, 16'h0020, 1, 1, 16'h0060, 0, 16'h0000, 16'h0020, 0, 16'h0000, 1, 16'h0060);
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 0, 16'h0000, 0, 16'h0002);
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0020, 1, 16'h0060, 0, 16'h0002);
    add(0, 16'h0030, 1, 1, 16'h0080, 0, 16'h0000, 16'h0020, 1, 16'h0060, 1, 16'h0080);
    add(0, 16'h0030, 1, 0, 16'h0080, 0, 16'h0000, 16'h0020, 1, 16'h0060, 0, 16'h0032);
    add(0, 16'hFFFE, 1, 0, 16'h0080, 0, 16'h0000, 16'h0020, 1, 16'h0060, 0, 16'h0000);
    add(0, 16'h0030, 0, 0, 16'h0080, 1, 16'h0000, 16'h0020, 1, 16'h0060, 0, 16'h0032);
    add(1, 16'h0104, 1, 0, 16'h0200, 0, 16'h0000, 16'h0104, 0, 16'h0000, 0, 16'h0106);
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0104, 0, 16'h0200, 0, 16'h0002);
    add(1, 16'h0104, 1, 1, 16'h0300, 0, 16'h0200, 16'h0104, 0, 16'h0200, 1, 16'h0300);
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0104, 1, 16'h0300, 0, 16'h0002);

    rst = 1'b1;
    drive_idle(16'h0010);
    #2;
    check_lookup("reset", 1'b0, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      update_en           = vecs[i].upd;
      ID_PC               = vecs[i].id_pc;
      ID_is_branch        = vecs[i].br;
      ID_actual_taken     = vecs[i].at;
      ID_actual_target    = vecs[i].atgt;
      ID_predicted_taken  = vecs[i].pt;
      ID_predicted_target = vecs[i].ptgt;
      PC_curr             = vecs[i].lpc;
      e = '{vecs[i].e_t, vecs[i].e_tgt, vecs[i].e_mp, vecs[i].e_cpc};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d.taken", i), {15'd0, predicted_taken}, {15'd0, e.e_t});
      check($sformatf("v%0d.target", i), predicted_target, e.e_tgt);
      check($sformatf("v%0d.mispred", i), {15'd0, mispredicted}, {15'd0, e.e_mp});
      check($sformatf("v%0d.correct_pc", i), correct_PC, e.e_cpc);
    end

    // Asynchronous reset mid-cycle clears the prediction immediately.
    @(negedge clk);
    drive_idle(16'h0020);
    #1;
    check_lookup("pre_rst", 1'b1, 16'h0060);
    #1 rst = 1'b1;
    #1;
    check_lookup("async_rst", 1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    PC_curr = 16'h0104;
    #1;
    check_lookup("after_rst", 1'b0, 16'h0000);

    // Reset held across an edge with an update pending cancels the update.
    @(negedge clk);
    drive_idle(16'h0010);
    update_en = 1; ID_PC = 16'h0010; ID_is_branch = 1;
    ID_actual_taken = 1; ID_actual_target = 16'h0044;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_idle(16'h0010);
    #1;
    check_lookup("rst_cancel", 1'b0, 16'h0000);

    // A single taken update after reset allocates as weak-taken.
    @(negedge clk);
    update_en = 1; ID_PC = 16'h0010; ID_is_branch = 1;
    ID_actual_taken = 1; ID_actual_target = 16'h0044;
    @(negedge clk);
    drive_idle(16'h0010);
    #1;
    check_lookup("realloc", 1'b1, 16'h0044);

    if (sb.size() != 0) check("scoreboard_empty", 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
